frogger_score_display: RTL and testbench
========================================

// Module: frogger_score_display
// PURPOSE
//  Parametrised N-digit BCD score counter with high-score register, driving the
//  board's active-low 7-segment HEX digits (replaces hard-blanked HEX1..HEX5).
//  Frogger game core pulses inc per scored hop, clear on new game.
//  Sits beside the game core, clocked from the same divided clock.
// PARAMETERS
//  DIGITS         4   BCD digits / HEX displays driven (1..6)
//  BLINK_W        8   blink counter width; display phase = counter MSB
//  BLANK_LEADING  1   1 = blank leading zero digits; 0 = show all digits
// PORTS
//  clock      in   1          game clock, all state on rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  inc        in   1          +1 point request, one cycle = one point
//  clear      in   1          end game: commit high score, zero score
//  show_high  in   1          1 = display high score, 0 = current score
//  blink_en   in   1          1 = flash display at blink rate
//  score_bcd  out  4*DIGITS   current score, packed BCD, digit0 = LSBs
//  high_bcd   out  4*DIGITS   high score, packed BCD
//  overflow   out  1          sticky: increment attempted at all-9s
//  hex        out  7*DIGITS   active-low segments, hex[6:0] = digit0
// BEHAVIOUR
//  Reset (async, reset_n=0): score=0, high=0, overflow=0, blink counter=0,
//   hex digit0=7'b1000000, other digits 7'b1111111 (BLANK_LEADING=1) or
//   7'b1000000 (BLANK_LEADING=0).
//  Increment: inc=1 & !clear -> score+1 in BCD, carry ripples through all
//   digits in the same cycle; digit 9->0 with carry. Score at all-9s:
//   score holds (saturates), overflow<=1.
//  Clear: clear=1 -> if score > high (unsigned BCD compare) high<=score;
//   score<=0; overflow<=0. Clear wins over simultaneous inc (inc dropped).
//  The compare uses the pre-clear score value of that cycle.
//  Display: shown = show_high ? high : score (registered values).
//   hex is registered: reflects shown value 1 cycle after it changes
//   (inc at edge N -> score at N+1 -> hex at N+2).
//  Leading blanking: digit i blank iff BLANK_LEADING and i>0 and
//   digits i..DIGITS-1 of shown are all 0; digit0 always shown.
//  Blink: free-running BLINK_W counter, wraps at 2^BLINK_W-1 -> 0.
//   blink_en=1 and counter MSB=1 -> all hex = 7'b1111111.
//   blink_en=0 -> normal display.
//  Segment codes (gfedcba, active-low): 0=1000000 1=1111001 2=0100100
//   3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000;
//   invalid nibble (unreachable) -> 7'b1111111.
//  reset_n assert mid-count returns all state to reset values immediately.
//   High score is not retained across reset.
// STRUCTURE
//  frogger_pkg: SEG_BLANK constant, seg7 code table, function
//   bcd_to_seg(logic [3:0]) -> logic [6:0].
//  Sub-module bcd_digit: one 4-bit BCD digit with cin/cout, inc, clear;
//   instantiated DIGITS times via generate.
//  Top holds saturation detect, high-score compare/load, blanking mask,
//   blink counter and the output register.
// TESTING
//  Reset release, DIGITS=4 -> hex[6:0]=1000000, hex[27:7] all 1s, score_bcd=0.
//  12 inc pulses -> score_bcd=16'h0012; hex[13:7]=1111001,
//   hex[6:0]=0100100, digits 2,3 blank.
//  Score 0099 + 1 inc -> 16'h0100 in one cycle; hex shows "100" two cycles
//   after the inc edge.
//  9999 incs then 1 more -> score 16'h9999 holds, overflow=1;
//   clear -> score 0, high 16'h9999, overflow 0.
//  high=0042, score=0017, inc&clear same cycle -> score 0, high stays 0042;
//   show_high=1 -> hex shows "42".
//  BLINK_W=4, blink_en=1 -> hex all 1s for 8 cycles, digits for 8 cycles,
//   repeating; reset_n=0 mid-phase -> reset display immediately.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared constants and the 7-segment decoder for the Frogger score display.
// Segment order is gfedcba, active-low, matching the board HEX digits.
package frogger_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the score counter; cout means "this and all lower digits
// are at 9", so chaining cin/cout gives a full same-cycle ripple carry.
module bcd_digit (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clear,
    input  logic       cin,
    output logic       cout,
    output logic [3:0] digit
);

    assign cout = cin & (digit == 4'd9);

    // Clear takes priority so an increment in the same cycle is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit <= 4'd0;
        end else if (clear) begin
            digit <= 4'd0;
        end else if (inc && cin) begin
            digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/frogger_score_display.sv
// N-digit BCD score counter with high-score register, leading-zero blanking
// and optional blinking, driving active-low 7-segment HEX displays.
module frogger_score_display #(
    parameter int DIGITS        = 4,
    parameter int BLINK_W       = 8,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  clear,
    input  logic                  show_high,
    input  logic                  blink_en,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);
    import frogger_pkg::*;

    logic [DIGITS:0]       carry;
    logic                  saturated;
    logic                  digit_inc;
    logic [4*DIGITS-1:0]   shown;
    logic [DIGITS:0]       nonzero_above;
    logic [7*DIGITS-1:0]   hex_next;
    logic [BLINK_W-1:0]    blink_cnt;

    // The carry out of the top digit is set exactly when every digit is 9.
    assign carry[0]  = 1'b1;
    assign saturated = carry[DIGITS];
    assign digit_inc = inc & ~saturated;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clock   (clock),
            .reset_n (reset_n),
            .inc     (digit_inc),
            .clear   (clear),
            .cin     (carry[g]),
            .cout    (carry[g+1]),
            .digit   (score_bcd[4*g +: 4])
        );
    end

    // Packed BCD orders the same as plain binary, so a direct compare works.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            high_bcd <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            if (score_bcd > high_bcd) begin
                high_bcd <= score_bcd;
            end
            overflow <= 1'b0;
        end else if (inc && saturated) begin
            overflow <= 1'b1;
        end
    end

    assign shown = show_high ? high_bcd : score_bcd;

    always_comb begin
        nonzero_above         = '0;
        hex_next              = '0;
        nonzero_above[DIGITS] = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nonzero_above[i] = (|shown[4*i +: 4]) | nonzero_above[i+1];
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (blink_en && blink_cnt[BLINK_W-1]) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end else if (BLANK_LEADING != 0 && i > 0 && !nonzero_above[i]) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*i +: 7] = bcd_to_seg(shown[4*i +: 4]);
            end
        end
    end

    // Reset pattern matches what a zero score decodes to, so no glitch on release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                hex[7*i +: 7] <= (i == 0 || BLANK_LEADING == 0) ? SEG_ZERO : SEG_BLANK;
            end
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
            hex       <= hex_next;
        end
    end

endmodule

// File: tb/tb_frogger_score_display.sv
// Randomised self-checking bench for frogger_score_display against a decimal
// arithmetic model of score, high score, overflow, blink phase and display.
module tb_frogger_score_display;

    localparam int DIGITS  = 4;
    localparam int BLINK_W = 4;
    localparam int HALF    = 1 << (BLINK_W - 1);
    localparam int PERIOD  = 1 << BLINK_W;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        inc       = 1'b0;
    logic        clear     = 1'b0;
    logic        show_high = 1'b0;
    logic        blink_en  = 1'b0;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic        overflow;
    logic [27:0] hex;

    int checks = 0;
    int errors = 0;

    int          m_score;
    int          m_high;
    int          m_cnt;
    logic        m_ovf;
    logic [27:0] m_hex;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    frogger_score_display #(
        .DIGITS        (DIGITS),
        .BLINK_W       (BLINK_W),
        .BLANK_LEADING (1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc       (inc),
        .clear     (clear),
        .show_high (show_high),
        .blink_en  (blink_en),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .overflow  (overflow),
        .hex       (hex)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] enc_hex(input int v);
        logic [27:0] r;
        int p;
        int d;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = (v / p) % 10;
            if (i > 0 && v < p) r[7*i +: 7] = 7'h7f;
            else                r[7*i +: 7] = seg_tab[d];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_score = 0;
        m_high  = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_hex   = enc_hex(0);
    endtask

    task automatic do_reset();
        inc     = 1'b0;
        clear   = 1'b0;
        reset_n = 1'b0;
        #12;
        model_reset();
        reset_n = 1'b1;
    endtask

    // One clock edge: drive inputs, advance the model with the pre-edge state.
    task automatic step(input logic i_inc, input logic i_clear);
        int shown;
        inc   = i_inc;
        clear = i_clear;
        @(posedge clock);
        shown = show_high ? m_high : m_score;
        m_hex = (blink_en && m_cnt >= HALF) ? 28'hfffffff : enc_hex(shown);
        if (i_clear) begin
            if (m_score > m_high) m_high = m_score;
            m_score = 0;
            m_ovf   = 1'b0;
        end else if (i_inc) begin
            if (m_score == 9999) m_ovf = 1'b1;
            else                 m_score = m_score + 1;
        end
        m_cnt = (m_cnt + 1) % PERIOD;
        #1;
        inc   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (score_bcd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_score got %h expected 0000", score_bcd);
        end
        checks++;
        if (high_bcd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_high got %h expected 0000", high_bcd);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_overflow got %b expected 0", overflow);
        end
        checks++;
        if (hex !== {21'h1fffff, 7'b1000000}) begin
            errors++;
            $display("[TB] FAIL reset_hex got %h expected %h", hex, {21'h1fffff, 7'b1000000});
        end
    endtask

    task automatic test_count();
        do_reset();
        repeat (12) step(1'b1, 1'b0);
        checks++;
        if (score_bcd !== 16'h0012) begin
            errors++;
            $display("[TB] FAIL count12_score got %h expected 0012", score_bcd);
        end
        step(1'b0, 1'b0);
        checks++;
        if (hex !== {14'h3fff, 7'b1111001, 7'b0100100}) begin
            errors++;
            $display("[TB] FAIL count12_hex got %h expected %h", hex, {14'h3fff, 7'b1111001, 7'b0100100});
        end
    endtask

    task automatic test_carry();
        do_reset();
        repeat (99) step(1'b1, 1'b0);
        checks++;
        if (score_bcd !== 16'h0099) begin
            errors++;
            $display("[TB] FAIL carry_pre got %h expected 0099", score_bcd);
        end
        step(1'b1, 1'b0);
        checks++;
        if (score_bcd !== 16'h0100) begin
            errors++;
            $display("[TB] FAIL carry_score got %h expected 0100", score_bcd);
        end
        checks++;
        if (hex !== m_hex) begin
            errors++;
            $display("[TB] FAIL carry_hex_lag got %h expected %h", hex, m_hex);
        end
        step(1'b0, 1'b0);
        checks++;
        if (hex !== {7'h7f, 7'b1111001, 7'b1000000, 7'b1000000}) begin
            errors++;
            $display("[TB] FAIL carry_hex got %h expected %h", hex, {7'h7f, 7'b1111001, 7'b1000000, 7'b1000000});
        end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (9999) step(1'b1, 1'b0);
        checks++;
        if (score_bcd !== 16'h9999 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_reach got %h/%b expected 9999/0", score_bcd, overflow);
        end
        step(1'b1, 1'b0);
        checks++;
        if (score_bcd !== 16'h9999 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_hold got %h/%b expected 9999/1", score_bcd, overflow);
        end
        step(1'b0, 1'b1);
        checks++;
        if (score_bcd !== 16'h0000 || high_bcd !== 16'h9999 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_clear got %h/%h/%b expected 0000/9999/0", score_bcd, high_bcd, overflow);
        end
    endtask

    task automatic test_inc_clear();
        do_reset();
        repeat (42) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (17) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (score_bcd !== 16'h0000 || high_bcd !== 16'h0042) begin
            errors++;
            $display("[TB] FAIL incclr got %h/%h expected 0000/0042", score_bcd, high_bcd);
        end
        show_high = 1'b1;
        step(1'b0, 1'b0);
        checks++;
        if (hex !== {14'h3fff, 7'b0011001, 7'b0100100}) begin
            errors++;
            $display("[TB] FAIL show_high_hex got %h expected %h", hex, {14'h3fff, 7'b0011001, 7'b0100100});
        end
        show_high = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) show_high = ~show_high;
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 24) == 0));
            checks++;
            if (score_bcd !== to_bcd(m_score) || high_bcd !== to_bcd(m_high) ||
                overflow !== m_ovf || hex !== m_hex) begin
                errors++;
                $display("[TB] FAIL random cycle %0d got %h/%h/%b/%h expected %h/%h/%b/%h", n,
                         score_bcd, high_bcd, overflow, hex,
                         to_bcd(m_score), to_bcd(m_high), m_ovf, m_hex);
            end
        end
        show_high = 1'b0;
    endtask

    task automatic test_blink();
        int blanks;
        do_reset();
        blink_en = 1'b1;
        blanks   = 0;
        for (int n = 0; n < 3 * PERIOD; n++) begin
            step(logic'($urandom_range(0, 1)), logic'(n == 20));
            if (m_hex === 28'hfffffff) blanks++;
            checks++;
            if (hex !== m_hex) begin
                errors++;
                $display("[TB] FAIL blink cycle %0d got %h expected %h", n, hex, m_hex);
            end
        end
        checks++;
        if (blanks != 3 * HALF) begin
            errors++;
            $display("[TB] FAIL blink_duty got %0d blank cycles expected %0d", blanks, 3 * HALF);
        end
        repeat (12) step(1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (hex !== {21'h1fffff, 7'b1000000} || score_bcd !== 16'h0000 || high_bcd !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midreset got %h/%h/%h expected %h/0000/0000",
                     hex, score_bcd, high_bcd, {21'h1fffff, 7'b1000000});
        end
        #3;
        model_reset();
        reset_n = 1'b1;
        blink_en = 1'b0;
        step(1'b1, 1'b0);
        checks++;
        if (score_bcd !== 16'h0001 || hex !== m_hex) begin
            errors++;
            $display("[TB] FAIL post_reset got %h/%h expected 0001/%h", score_bcd, hex, m_hex);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry();
        test_saturate();
        test_inc_clear();
        test_random();
        test_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
